// File: rtl/trajectory_interp_pkg.sv
// trajectory_interp_pkg: shared state encoding and axis position width for trajectory stages
package trajectory_interp_pkg;
  localparam int POS_W = 32;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
endpackage

// File: rtl/trajectory_interp_axis.sv
// interp_axis: one axis's start/end/delta/accumulator registers and the interpolated output add
module interp_axis
  import trajectory_interp_pkg::*;
#(
  parameter int SEG_SHIFT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             init,
  input  logic             step,
  input  logic [POS_W-1:0] start_pos,
  input  logic [POS_W-1:0] end_pos,
  output logic [POS_W-1:0] pos
);
  logic [POS_W-1:0] start_q, end_q;
  logic [POS_W:0] delta;
  logic signed [POS_W+SEG_SHIFT:0] acc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= '0;
      end_q   <= '0;
      delta   <= '0;
      acc     <= '0;
    end else begin
      if (load) begin
        start_q <= start_pos;
        end_q   <= end_pos;
      end
      if (init) begin
        delta <= {end_q[POS_W-1], end_q} - {start_q[POS_W-1], start_q};
        acc   <= '0;
      end else if (step) begin
        acc <= acc + {{SEG_SHIFT{delta[POS_W]}}, delta};
      end
    end
  end
  // arithmetic shift floors toward -inf; 2^SEG_SHIFT * delta >>> SEG_SHIFT lands exactly on end
  assign pos = start_q + POS_W'(acc >>> SEG_SHIFT);
endmodule

// File: rtl/trajectory_interp.sv
// trajectory_interp: segment FSM and step counter driving per-axis linear interpolators
module trajectory_interp
  import trajectory_interp_pkg::*;
#(
  parameter int STEPPERS_NUM = 6,
  parameter int SEG_SHIFT    = 4
) (
  input  logic                            CLK,
  input  logic                            RST_n,
  input  logic [POS_W*STEPPERS_NUM-1:0]   startConfig,
  input  logic [POS_W*STEPPERS_NUM-1:0]   endConfig,
  input  logic                            start,
  input  logic                            abort,
  output logic                            busy,
  output logic [POS_W*STEPPERS_NUM-1:0]   stepperPosition,
  output logic                            posValid,
  input  logic                            posReady,
  output logic                            posLast
);
  state_t state, next_state;
  logic [SEG_SHIFT:0] k;
  logic accept, step;
  assign posValid = state == RUN;
  assign posLast  = posValid & k[SEG_SHIFT];
  assign busy     = state != IDLE;
  assign accept   = posValid & posReady & ~abort;
  assign step     = accept & ~k[SEG_SHIFT];
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state <= IDLE;
      k     <= '0;
    end else begin
      state <= next_state;
      k     <= state == LOAD ? '0 : step ? k + 1'b1 : k;
    end
  end
  always_comb begin
    next_state = state;
    next_state = state == IDLE ? (start ? LOAD : IDLE) :
                 abort         ? IDLE :
                 state == LOAD ? RUN :
                 state == DONE ? IDLE :
                 (accept & k[SEG_SHIFT]) ? DONE : RUN;
  end
  for (genvar i = 0; i < STEPPERS_NUM; i++) begin : g_axis
    interp_axis #(.SEG_SHIFT(SEG_SHIFT)) u_axis (
      .clk       (CLK),
      .rst_n     (RST_n),
      .load      (state == IDLE && start),
      .init      (state == LOAD),
      .step      (step),
      .start_pos (startConfig[POS_W*i +: POS_W]),
      .end_pos   (endConfig[POS_W*i +: POS_W]),
      .pos       (stepperPosition[POS_W*i +: POS_W])
    );
  end
endmodule

// File: tb/tb_trajectory_interp.sv
// tb_trajectory_interp: scoreboard bench for the segment interpolator
module tb_trajectory_interp;
  localparam int N = 6;
  localparam int S = 4;
  localparam int W = 32 * N;
  localparam int NS = (1 << S) + 1;

  typedef struct {
    logic [W-1:0] pos;
    logic         last;
  } smp_t;

  logic CLK = 0, RST_n = 0, start = 0, abort = 0, posReady = 0;
  logic [W-1:0] startConfig = '0, endConfig = '0;
  logic busy, posValid, posLast;
  logic [W-1:0] stepperPosition;

  int checks = 0, errors = 0, acc_cnt = 0;
  smp_t q[$];
  smp_t cur;

  trajectory_interp #(.STEPPERS_NUM(N), .SEG_SHIFT(S)) dut (
    .CLK(CLK), .RST_n(RST_n), .startConfig(startConfig), .endConfig(endConfig),
    .start(start), .abort(abort), .busy(busy), .stepperPosition(stepperPosition),
    .posValid(posValid), .posReady(posReady), .posLast(posLast)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] s, input logic [W-1:0] e, input int k);
    logic [W-1:0] r;
    for (int a = 0; a < N; a++) begin
      longint st, d, v;
      st = longint'($signed(s[32*a +: 32]));
      d  = longint'($signed(e[32*a +: 32])) - st;
      v  = st + ((d * k) >>> S);
      r[32*a +: 32] = v[31:0];
    end
    return r;
  endfunction

  task automatic push_seg(input logic [W-1:0] s, input logic [W-1:0] e);
    for (int k = 0; k < NS; k++) q.push_back('{model(s, e, k), k == NS - 1});
  endtask

  task automatic start_seg(input logic [W-1:0] s, input logic [W-1:0] e);
    startConfig = s;
    endConfig = e;
    push_seg(s, e);
    start = 1;
    @(posedge CLK); #1;
    start = 0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(posedge CLK); #1;
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  always @(negedge CLK) begin
    if (RST_n && posValid && posReady && !abort) begin
      if (q.size() == 0) check("extra_sample", 1, 0);
      else begin
        cur = q.pop_front();
        check("pos", stepperPosition, cur.pos);
        check("last", posLast, cur.last);
      end
      acc_cnt++;
    end else if (RST_n && posValid && !posReady && q.size() > 0) begin
      check("stall_pos", stepperPosition, q[0].pos);
    end
  end

  function automatic logic [W-1:0] pack(input logic [31:0] a0, a1, a2, a3, a4, a5);
    return {a5, a4, a3, a2, a1, a0};
  endfunction

  initial begin
    logic [W-1:0] s1, e1, s2, e2;
    int base;
    s1 = pack(32'd0, 32'd100, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h1234_5678, 32'h8000_0000);
    e1 = pack(32'd160, -32'sd60, 32'd1, 32'h8000_0000, 32'h1234_5678, 32'h7FFF_FFFF);
    s2 = pack(-32'sd500, 32'd7, 32'd0, 32'd1000, 32'hDEAD_BEEF, 32'd3);
    e2 = pack(32'd500, -32'sd9, 32'd15, 32'd999, 32'h0BAD_F00D, 32'd3);

    #12;
    check("rst_busy", busy, 0);
    check("rst_valid", posValid, 0);
    check("rst_last", posLast, 0);
    check("rst_pos", stepperPosition, 0);
    @(posedge CLK); #1;
    RST_n = 1;
    posReady = 1;
    @(posedge CLK); #1;

    // full-throughput segment with latency and busy timing
    acc_cnt = 0;
    start_seg(s1, e1);
    check("load_valid", posValid, 0);
    check("load_busy", busy, 1);
    @(posedge CLK); #1;
    check("run_valid", posValid, 1);
    check("first_pos", stepperPosition, s1);
    repeat (NS) @(posedge CLK);
    #1;
    check("accepts_full", acc_cnt, NS);
    check("done_valid", posValid, 0);
    check("done_busy", busy, 1);
    @(posedge CLK); #1;
    check("idle_busy", busy, 0);
    check("end_pos", stepperPosition, e1);

    // random backpressure
    acc_cnt = 0;
    start_seg(s2, e2);
    for (int n = 0; n < 400 && busy; n++) begin
      posReady = 1'($urandom_range(0, 1));
      @(posedge CLK); #1;
    end
    check("accepts_rand", acc_cnt, NS);
    check("q_empty_rand", q.size(), 0);
    posReady = 1;
    @(posedge CLK); #1;

    // abort at k=5 alongside posReady
    acc_cnt = 0;
    start_seg(s1, e1);
    for (int n = 0; n < 50 && acc_cnt < 5; n++) begin
      @(posedge CLK); #1;
    end
    check("abort_k", stepperPosition, model(s1, e1, 5));
    abort = 1;
    @(posedge CLK); #1;
    abort = 0;
    check("abort_valid", posValid, 0);
    check("abort_busy", busy, 0);
    check("abort_accepts", acc_cnt, 5);
    q.delete();
    acc_cnt = 0;
    start_seg(s2, e2);
    @(posedge CLK); #1;
    check("restart_pos", stepperPosition, s2);
    wait_idle(100);
    check("accepts_restart", acc_cnt, NS);

    // async reset mid-run
    acc_cnt = 0;
    start_seg(s1, e1);
    repeat (6) @(posedge CLK);
    #3;
    RST_n = 0;
    #1;
    check("arst_pos", stepperPosition, 0);
    check("arst_valid", posValid, 0);
    check("arst_busy", busy, 0);
    check("arst_last", posLast, 0);
    q.delete();
    start = 1;
    repeat (2) @(posedge CLK);
    #2;
    start = 0;
    #2;
    RST_n = 1;
    @(posedge CLK); #1;
    check("post_rst_busy", busy, 0);
    check("post_rst_pos", stepperPosition, 0);
    acc_cnt = 0;
    start_seg(s2, e2);
    wait_idle(100);
    check("accepts_post_rst", acc_cnt, NS);

    // start held high: one segment per IDLE entry
    acc_cnt = 0;
    startConfig = s1;
    endConfig = e1;
    push_seg(s1, e1);
    start = 1;
    @(posedge CLK); #1;
    base = 0;
    while (busy && base < 100) begin
      @(posedge CLK); #1;
      base++;
    end
    start = 0;
    check("hold_idle", busy, 0);
    repeat (4) @(posedge CLK);
    #1;
    check("hold_accepts", acc_cnt, NS);
    check("hold_q_empty", q.size(), 0);
    check("hold_stay_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/trajectory_interp.md
TRAJECTORY_INTERP -- requirements
Module: trajectory_interp

Interface
REQ-001 Parameter STEPPERS_NUM, default 6: number of joint axes; each axis position is 32-bit two's-complement.
REQ-002 Parameter SEG_SHIFT, default 4: a segment is divided into 2^SEG_SHIFT steps, giving 2^SEG_SHIFT+1 samples; legal range 1..16.
REQ-003 CLK  input  1: sole clock; all state updates on rising edge.
REQ-004 RST_n  input  1: asynchronous, active-low reset.
REQ-005 startConfig  input  32*STEPPERS_NUM: segment start position; axis i occupies bits [32i+31:32i].
REQ-006 endConfig  input  32*STEPPERS_NUM: segment end position; same packing.
REQ-007 start  input  1: one-cycle request to begin a segment; sampled only in IDLE.
REQ-008 abort  input  1: cancels the current segment.
REQ-009 busy  output  1: high in any state other than IDLE.
REQ-010 stepperPosition  output  32*STEPPERS_NUM: current interpolated sample, packed as in REQ-005; feeds the trajectory judge.
REQ-011 posValid  output  1: stepperPosition holds a valid sample.
REQ-012 posReady  input  1: downstream accepts the sample when posValid and posReady are both high on a rising edge.
REQ-013 posLast  output  1: high together with posValid on the final sample (k = 2^SEG_SHIFT).

Function
REQ-014 States: IDLE, LOAD, RUN, DONE.
REQ-015 IDLE: start=1 -> LOAD. Register startConfig and endConfig. Ignore start in every other state.
REQ-016 LOAD: per axis, delta_i = end_i - start_i as 33-bit signed. acc_i := 0. k := 0. Next state RUN.
REQ-017 RUN: posValid=1. stepperPosition_i = start_i + (acc_i >>> SEG_SHIFT), using an arithmetic shift (floor) and truncating the result to 32 bits.
REQ-018 acc_i width is 33+SEG_SHIFT bits; it never overflows.
REQ-019 On acceptance with k < 2^SEG_SHIFT: acc_i += delta_i and k += 1. The new sample is visible the next cycle (one sample per cycle at full throughput).
REQ-020 On acceptance with k = 2^SEG_SHIFT (posLast=1): next state DONE. The final sample equals endConfig exactly.
REQ-021 While posValid=1 and posReady=0: stepperPosition, posLast and k hold stable.
REQ-022 DONE: posValid=0 for one cycle, then go to IDLE. A new start is accepted from IDLE in the following cycle.
REQ-023 abort=1 in LOAD, RUN or DONE -> IDLE on the next edge, with posValid=0. abort has priority over acceptance in the same cycle. abort in IDLE has no effect.
REQ-024 startConfig equal to endConfig is legal: all 2^SEG_SHIFT+1 samples equal startConfig.
REQ-025 Negative deltas and sign-crossing segments interpolate monotonically toward endConfig.
REQ-026 Latency: first sample valid 2 cycles after the start edge (IDLE->LOAD->RUN).

Reset
REQ-027 On RST_n=0, asynchronously: state=IDLE, posValid=0, posLast=0, busy=0, stepperPosition=0, k=0, acc=0, registered configs=0.
REQ-028 Reset asserted mid-segment discards the segment. After release the block stays in IDLE until a new start.

Structure
REQ-029 The state encoding and the per-axis position width (32) belong in a shared package used by all trajectory stages.
REQ-030 One sub-module, interp_axis, SHALL hold one axis's start, delta and acc registers and the output add. It is instantiated STEPPERS_NUM times by generate; the FSM and k counter stay in trajectory_interp.

Verification
REQ-031 SEG_SHIFT=4, axis0 0 -> 160, posReady=1 -> 17 samples 0,10,20,...,160 on consecutive cycles; posLast only on 160; busy falls 2 cycles after the last sample.
REQ-032 Axis1 100 -> -60 (delta -160) -> samples 100,90,...,-60; axis2 -1 -> 1 (delta 2) -> floor steps: -1 for k=0..7, 0 for k=8..15, 1 at k=16.
REQ-033 posReady toggled pseudo-randomly -> no sample lost or duplicated; stepperPosition stable while stalled; 17 accepted transfers.
REQ-034 abort asserted at k=5 together with posReady=1 -> posValid=0 next cycle, state IDLE; a new start then restarts from k=0 with the new configs.
REQ-035 RST_n pulsed low mid-RUN, asynchronous to CLK -> outputs zero immediately; start ignored during reset; a normal segment completes after release.
REQ-036 start held high across a whole segment -> exactly one segment per IDLE entry; axis 0x7FFFFFFF -> 0x80000000 interpolates through all 33-bit deltas with no wrap before the final sample.
